// File: rtl/dmem_arbiter.sv
// Two-port arbiter and single-cycle access sequencer for the 4096 x 20-bit data memory.
// Optional feature macro: DMEM_ARB_RR_EN (round-robin on IDLE ties; fixed A-over-B otherwise).
module dmem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 20
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ReqA,
    input  logic              ReqB,
    input  logic              WriteA,
    input  logic              WriteB,
    input  logic [ADDR_W-1:0] AddrA,
    input  logic [ADDR_W-1:0] AddrB,
    input  logic [DATA_W-1:0] WDataA,
    input  logic [DATA_W-1:0] WDataB,
    output logic              AckA,
    output logic              AckB,
    output logic [DATA_W-1:0] RDataA,
    output logic [DATA_W-1:0] RDataB,
    output logic              GrantA,
    output logic              GrantB,
    output logic              Busy,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemDataInput,
    output logic              MemLoadEnable,
    output logic              MemWriteEnable,
    input  logic [DATA_W-1:0] MemDataOutput
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic              req;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } port_req_t;

    // Port index 0 is A, 1 is B.
    port_req_t [1:0] port;
    assign port[0] = {ReqA, WriteA, AddrA, WDataA};
    assign port[1] = {ReqB, WriteB, AddrB, WDataB};

    state_t                   state_q, state_d;
    logic                     gnt_q, gnt_d;
    logic                     last_q, last_d;
    logic [1:0]               ack_q, ack_d;
    logic [1:0][DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]               grant;
    logic                     tie_pick;
    logic                     idle_pick;
    port_req_t                sel;

`ifdef DMEM_ARB_RR_EN
    assign tie_pick = ~last_q;
`else
    assign tie_pick = 1'b0;
`endif

    // With only one requester it wins outright; ties go to the policy pick.
    assign idle_pick = (port[0].req & port[1].req) ? tie_pick : port[1].req;

    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        last_d         = last_q;
        ack_d          = '0;
        rdata_d        = rdata_q;
        grant          = '0;
        sel            = port[gnt_q];
        MemAddress     = '0;
        MemDataInput   = '0;
        MemLoadEnable  = 1'b0;
        MemWriteEnable = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (port[0].req | port[1].req) begin
                    gnt_d   = idle_pick;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                MemAddress     = sel.addr;
                MemDataInput   = sel.wdata;
                MemLoadEnable  = ~sel.wr;
                // Gating with reset keeps an aborted write from landing.
                MemWriteEnable = sel.wr & reset_n;
                grant[gnt_q]   = 1'b1;
                if (!sel.wr) begin
                    rdata_d[gnt_q] = MemDataOutput;
                end
                ack_d[gnt_q] = 1'b1;
                last_d       = gnt_q;
                state_d      = S_DONE;
            end
            S_DONE: begin
                // The port just served still holds Req this cycle, so only the other one may win.
                if (port[~gnt_q].req) begin
                    gnt_d   = ~gnt_q;
                    state_d = S_ACCESS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            ack_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    assign AckA   = ack_q[0];
    assign AckB   = ack_q[1];
    assign RDataA = rdata_q[0];
    assign RDataB = rdata_q[1];
    assign GrantA = grant[0];
    assign GrantB = grant[1];
    assign Busy   = (state_q != S_IDLE);

endmodule
